// File: rtl/dma_csr_mc.sv
// Multi-channel DMA register block. Each channel holds SRC/DST/LEN/CTRL/STATUS
// registers and a three-state FSM (IDLE, PEND, ACTIVE). A round-robin arbiter
// hands one pending channel at a time to a single shared DMA engine.
//
// Config port handshake: there is no ready. A request is taken in every cycle
// where cfg_req_valid=1. A read returns data one cycle later with
// cfg_resp_valid=1 for exactly that cycle. A write produces no response.
// Engine handshake: eng_start pulses for one cycle per grant. The eng_* command
// fields hold their values until the next grant. eng_done is a one-cycle pulse.
// eng_err is only meaningful while eng_done=1.
module dma_csr_mc #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 48,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_req_valid,
  input  logic                  cfg_req_write,
  input  logic [31:0]           cfg_req_addr,
  input  logic [31:0]           cfg_req_wdata,
  output logic                  cfg_resp_valid,
  output logic [31:0]           cfg_resp_rdata,
  output logic                  eng_start,
  output logic [ADDR_WIDTH-1:0] eng_src,
  output logic [ADDR_WIDTH-1:0] eng_dst,
  output logic [LEN_WIDTH-1:0]  eng_len,
  output logic [2:0]            eng_ch,
  input  logic                  eng_done,
  input  logic                  eng_err,
  output logic                  irq,
  output logic [2*NUM_CH-1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_ACTIVE = 2'd2
  } ch_state_e;

  localparam logic [4:0] OFF_SRC_LO = 5'h00;
  localparam logic [4:0] OFF_SRC_HI = 5'h04;
  localparam logic [4:0] OFF_DST_LO = 5'h08;
  localparam logic [4:0] OFF_DST_HI = 5'h0C;
  localparam logic [4:0] OFF_LEN    = 5'h10;
  localparam logic [4:0] OFF_CTRL   = 5'h14;
  localparam logic [4:0] OFF_STATUS = 5'h18;

  // Address bits at or above ADDR_WIDTH are never stored, so they read back as 0.
  localparam logic [63:0] ADDR_MASK = (ADDR_WIDTH >= 64) ? {64{1'b1}} :
                                      ((64'd1 << ADDR_WIDTH) - 64'd1);
  localparam logic [31:0] LEN_MASK  = (LEN_WIDTH >= 32) ? {32{1'b1}} :
                                      ((32'd1 << LEN_WIDTH) - 32'd1);

  ch_state_e state_q [NUM_CH];
  ch_state_e state_d [NUM_CH];

  logic [63:0] src_q [NUM_CH];
  logic [63:0] dst_q [NUM_CH];
  logic [31:0] len_q [NUM_CH];
  logic [NUM_CH-1:0] irq_en_q, done_q, err_q;
  logic [NUM_CH-1:0] done_set, err_set;
  logic [2:0]  rr_ptr;

  logic        wr_en, req_chan, req_glob;
  logic [2:0]  req_ch;
  logic [4:0]  req_off;
  logic [NUM_CH-1:0] ch_sel, ch_wr, start_req;

  logic        any_active, grant_vld;
  logic [2:0]  grant_ch;
  int          rr_idx;
  logic [ADDR_WIDTH-1:0] grant_src, grant_dst;
  logic [LEN_WIDTH-1:0]  grant_len;
  logic [31:0] rd_data;

  assign wr_en    = cfg_req_valid & cfg_req_write;
  assign req_ch   = cfg_req_addr[7:5];
  assign req_off  = cfg_req_addr[4:0];
  assign req_chan = (cfg_req_addr[31:8] == 24'd0) && (int'(req_ch) < NUM_CH);
  assign req_glob = (cfg_req_addr == 32'h0000_0200);

  // Decode the request into per-channel select, write and START strobes.
  always_comb begin
    ch_sel    = '0;
    ch_wr     = '0;
    start_req = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_sel[c]    = req_chan && (req_ch == 3'(c));
      ch_wr[c]     = wr_en && ch_sel[c];
      start_req[c] = ch_wr[c] && (req_off == OFF_CTRL) && cfg_req_wdata[0];
    end
  end

  // Round-robin arbiter and per-channel next-state logic.
  always_comb begin
    any_active = 1'b0;
    grant_vld  = 1'b0;
    grant_ch   = 3'd0;
    rr_idx     = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (state_q[c] == ST_ACTIVE) any_active = 1'b1;
    end
    // The engine is free only when no channel is ACTIVE. Scan from rr_ptr upward.
    if (!any_active) begin
      for (int k = 0; k < NUM_CH; k++) begin
        rr_idx = (int'(rr_ptr) + k) % NUM_CH;
        for (int c = 0; c < NUM_CH; c++) begin
          if (!grant_vld && (c == rr_idx) && (state_q[c] == ST_PEND)) begin
            grant_vld = 1'b1;
            grant_ch  = 3'(c);
          end
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]  = state_q[c];
      done_set[c] = 1'b0;
      err_set[c]  = 1'b0;
      case (state_q[c])
        ST_IDLE: begin
          if (start_req[c]) begin
            // A zero-length transfer completes at once without using the engine.
            if (len_q[c] != 32'd0) state_d[c] = ST_PEND;
            else                   done_set[c] = 1'b1;
          end
        end
        ST_PEND: begin
          if (grant_vld && (grant_ch == 3'(c))) state_d[c] = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (eng_done) begin
            state_d[c]  = ST_IDLE;
            done_set[c] = 1'b1;
            err_set[c]  = eng_err;
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

  // Select the command fields of the granted channel.
  always_comb begin
    grant_src = '0;
    grant_dst = '0;
    grant_len = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_ch == 3'(c)) begin
        grant_src = src_q[c][ADDR_WIDTH-1:0];
        grant_dst = dst_q[c][ADDR_WIDTH-1:0];
        grant_len = len_q[c][LEN_WIDTH-1:0];
      end
    end
  end

  // Channel FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= ST_IDLE;
    end else begin
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= state_d[c];
    end
  end

  // CSR storage, status flags, engine command and read response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        src_q[c] <= '0;
        dst_q[c] <= '0;
        len_q[c] <= '0;
      end
      irq_en_q       <= '0;
      done_q         <= '0;
      err_q          <= '0;
      rr_ptr         <= 3'd0;
      eng_start      <= 1'b0;
      eng_src        <= '0;
      eng_dst        <= '0;
      eng_len        <= '0;
      eng_ch         <= 3'd0;
      cfg_resp_valid <= 1'b0;
      cfg_resp_rdata <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // Address and length registers are frozen while a channel is busy.
        if (ch_wr[c]) begin
          case (req_off)
            OFF_SRC_LO: if (state_q[c] == ST_IDLE)
                          src_q[c] <= {src_q[c][63:32], cfg_req_wdata} & ADDR_MASK;
            OFF_SRC_HI: if (state_q[c] == ST_IDLE)
                          src_q[c] <= {cfg_req_wdata, src_q[c][31:0]} & ADDR_MASK;
            OFF_DST_LO: if (state_q[c] == ST_IDLE)
                          dst_q[c] <= {dst_q[c][63:32], cfg_req_wdata} & ADDR_MASK;
            OFF_DST_HI: if (state_q[c] == ST_IDLE)
                          dst_q[c] <= {cfg_req_wdata, dst_q[c][31:0]} & ADDR_MASK;
            OFF_LEN:    if (state_q[c] == ST_IDLE)
                          len_q[c] <= cfg_req_wdata & LEN_MASK;
            OFF_CTRL:   irq_en_q[c] <= cfg_req_wdata[1];
            default: ;
          endcase
        end
        // A set wins over a W1C that lands in the same cycle.
        if (done_set[c])
          done_q[c] <= 1'b1;
        else if (ch_wr[c] && (req_off == OFF_STATUS) && cfg_req_wdata[1])
          done_q[c] <= 1'b0;
        if (err_set[c])
          err_q[c] <= 1'b1;
        else if (ch_wr[c] && (req_off == OFF_STATUS) && cfg_req_wdata[2])
          err_q[c] <= 1'b0;
      end
      eng_start <= grant_vld;
      if (grant_vld) begin
        eng_src <= grant_src;
        eng_dst <= grant_dst;
        eng_len <= grant_len;
        eng_ch  <= grant_ch;
        rr_ptr  <= (int'(grant_ch) == NUM_CH - 1) ? 3'd0 : grant_ch + 3'd1;
      end
      cfg_resp_valid <= cfg_req_valid & ~cfg_req_write;
      cfg_resp_rdata <= rd_data;
    end
  end

  // Read data mux. Unmapped addresses and absent channels read as zero.
  always_comb begin
    rd_data = 32'd0;
    if (req_glob) begin
      rd_data = 32'(done_q | err_q);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel[c]) begin
          case (req_off)
            OFF_SRC_LO: rd_data = src_q[c][31:0];
            OFF_SRC_HI: rd_data = src_q[c][63:32];
            OFF_DST_LO: rd_data = dst_q[c][31:0];
            OFF_DST_HI: rd_data = dst_q[c][63:32];
            OFF_LEN:    rd_data = len_q[c];
            OFF_CTRL:   rd_data = {30'd0, irq_en_q[c], 1'b0};
            OFF_STATUS: rd_data = {29'd0, err_q[c], done_q[c], state_q[c] != ST_IDLE};
            default:    rd_data = 32'd0;
          endcase
        end
      end
    end
  end

  // Expose the channel FSM states, packed two bits per channel.
  always_comb begin
    dbg_state = '0;
    for (int c = 0; c < NUM_CH; c++) dbg_state[2*c +: 2] = state_q[c];
  end

  assign irq = |((done_q | err_q) & irq_en_q);

endmodule

// File: tb/tb_dma_csr_mc.sv
// Directed bench for dma_csr_mc. Inputs change on the falling edge.
// Outputs are sampled on the falling edge.
module tb_dma_csr_mc;

  localparam int NUM_CH = 4;
  localparam int AW     = 48;
  localparam int LW     = 32;

  logic          clk, rst_n;
  logic          cfg_req_valid, cfg_req_write;
  logic [31:0]   cfg_req_addr, cfg_req_wdata;
  logic          cfg_resp_valid;
  logic [31:0]   cfg_resp_rdata;
  logic          eng_start;
  logic [AW-1:0] eng_src, eng_dst;
  logic [LW-1:0] eng_len;
  logic [2:0]    eng_ch;
  logic          eng_done, eng_err, irq;
  logic [2*NUM_CH-1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [2:0]    gch_q[$];
  logic [AW-1:0] gsrc_q[$];
  logic [AW-1:0] gdst_q[$];
  logic [LW-1:0] glen_q[$];
  logic [2:0]    exp_q[$];

  dma_csr_mc #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_req_valid(cfg_req_valid), .cfg_req_write(cfg_req_write),
    .cfg_req_addr(cfg_req_addr), .cfg_req_wdata(cfg_req_wdata),
    .cfg_resp_valid(cfg_resp_valid), .cfg_resp_rdata(cfg_resp_rdata),
    .eng_start(eng_start), .eng_src(eng_src), .eng_dst(eng_dst),
    .eng_len(eng_len), .eng_ch(eng_ch),
    .eng_done(eng_done), .eng_err(eng_err), .irq(irq),
    .dbg_state(dbg_state)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every engine command cycle
  always @(negedge clk) begin
    if (eng_start) begin
      gch_q.push_back(eng_ch);
      gsrc_q.push_back(eng_src);
      gdst_q.push_back(eng_dst);
      glen_q.push_back(eng_len);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver tasks start and end on a falling edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cfg_req_valid = 1'b1; cfg_req_write = 1'b1; cfg_req_addr = a; cfg_req_wdata = d;
    @(negedge clk);
    cfg_req_valid = 1'b0; cfg_req_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
    cfg_req_valid = 1'b1; cfg_req_write = 1'b0; cfg_req_addr = a;
    @(negedge clk);
    cfg_req_valid = 1'b0;
    chk({tag, "_vld"}, 64'(cfg_resp_valid), 64'd1);
    chk(tag, 64'(cfg_resp_rdata), 64'(exp_v));
  endtask

  task automatic done_pulse(input logic e);
    eng_done = 1'b1; eng_err = e;
    @(negedge clk);
    eng_done = 1'b0; eng_err = 1'b0;
  endtask

  initial begin
    logic [2:0] ch;
    rst_n = 1'b0; cfg_req_valid = 1'b0; cfg_req_write = 1'b0;
    cfg_req_addr = '0; cfg_req_wdata = '0; eng_done = 1'b0; eng_err = 1'b0;
    idle(3);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_resp_valid", 64'(cfg_resp_valid), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    rst_n = 1'b1;
    idle(1);
    rd_chk("rst_status0", 32'h18, 32'h0);

    // Single transfer on ch0
    wr(32'h00, 32'h1000); wr(32'h04, 32'h0);
    wr(32'h08, 32'h2000); wr(32'h0C, 32'h0);
    wr(32'h10, 32'd64);
    wr(32'h14, 32'h1);
    chk("wr_no_resp", 64'(cfg_resp_valid), 64'd0);
    rd_chk("t1_busy", 32'h18, 32'h1);
    idle(3);
    chk("t1_one_grant", 64'(gch_q.size()), 64'd1);
    if (gch_q.size() > 0) begin
      chk("t1_ch", 64'(gch_q.pop_front()), 64'd0);
      chk("t1_src", 64'(gsrc_q.pop_front()), 64'h1000);
      chk("t1_dst", 64'(gdst_q.pop_front()), 64'h2000);
      chk("t1_len", 64'(glen_q.pop_front()), 64'd64);
    end
    chk("t1_start_low", 64'(eng_start), 64'd0);
    chk("t1_src_hold", 64'(eng_src), 64'h1000);
    rd_chk("t1_still_busy", 32'h18, 32'h1);
    done_pulse(1'b0);
    rd_chk("t1_done", 32'h18, 32'h2);

    // Address truncation and unmapped space
    wr(32'h04, 32'hFFFF_FFFF);
    rd_chk("src_hi_trunc", 32'h04, 32'h0000_FFFF);
    wr(32'h04, 32'h0);
    wr(32'h80, 32'h55);
    rd_chk("no_ch4", 32'h80, 32'h0);
    rd_chk("unmapped_1c", 32'h1C, 32'h0);
    rd_chk("unmapped_204", 32'h204, 32'h0);

    // Four channels started together, served round-robin
    for (int c = 0; c < 4; c++) begin
      wr(32'(c * 32), 32'(c * 256));
      wr(32'(c * 32 + 16), 32'd16);
    end
    for (int c = 0; c < 4; c++) begin
      wr(32'(c * 32 + 20), 32'h1);
      exp_q.push_back(3'(c));
    end
    idle(3);
    for (int k = 0; k < 4; k++) begin
      chk("rr_single", 64'(gch_q.size()), 64'd1);
      if (gch_q.size() > 0) begin
        ch = gch_q.pop_front();
        void'(gdst_q.pop_front()); void'(glen_q.pop_front());
        chk("rr_order", 64'(ch), 64'(exp_q.pop_front()));
        chk("rr_src", 64'(gsrc_q.pop_front()), 64'(k * 256));
      end
      done_pulse(1'b0);
      idle(3);
    end
    chk("rr_drained", 64'(gch_q.size()), 64'd0);

    // Zero-length start on ch1
    wr(32'h38, 32'h6);
    wr(32'h30, 32'h0);
    wr(32'h34, 32'h1);
    rd_chk("zero_len_done", 32'h38, 32'h2);
    idle(4);
    chk("zero_len_no_cmd", 64'(gch_q.size()), 64'd0);

    // Error completion with interrupt on ch3
    wr(32'h78, 32'h6);
    wr(32'h74, 32'h3);
    idle(3);
    chk("err_grant", 64'(gch_q.size()), 64'd1);
    if (gch_q.size() > 0) begin
      chk("err_ch", 64'(gch_q.pop_front()), 64'd3);
      void'(gsrc_q.pop_front()); void'(gdst_q.pop_front()); void'(glen_q.pop_front());
    end
    chk("irq_pre", 64'(irq), 64'd0);
    done_pulse(1'b1);
    rd_chk("err_status", 32'h78, 32'h6);
    chk("irq_set", 64'(irq), 64'd1);
    rd_chk("irq_stat", 32'h200, 32'hF);
    rd_chk("ctrl_read", 32'h74, 32'h2);
    wr(32'h78, 32'h6);
    rd_chk("err_cleared", 32'h78, 32'h0);
    chk("irq_clr", 64'(irq), 64'd0);
    rd_chk("irq_stat2", 32'h200, 32'h7);

    // Writes to a busy ch2 are dropped
    wr(32'h58, 32'h6);
    wr(32'h54, 32'h1);
    idle(3);
    chk("busy_grant", 64'(gch_q.size()), 64'd1);
    if (gch_q.size() > 0) begin
      chk("busy_ch", 64'(gch_q.pop_front()), 64'd2);
      void'(gsrc_q.pop_front()); void'(gdst_q.pop_front()); void'(glen_q.pop_front());
    end
    wr(32'h50, 32'h99);
    wr(32'h54, 32'h1);
    rd_chk("busy_len", 32'h50, 32'd16);
    idle(3);
    chk("busy_no_regrant", 64'(gch_q.size()), 64'd0);
    rd_chk("busy_status", 32'h58, 32'h1);
    // Completion and W1C of DONE in the same cycle: the set wins
    eng_done = 1'b1; eng_err = 1'b0;
    cfg_req_valid = 1'b1; cfg_req_write = 1'b1; cfg_req_addr = 32'h58; cfg_req_wdata = 32'h2;
    @(negedge clk);
    eng_done = 1'b0; cfg_req_valid = 1'b0; cfg_req_write = 1'b0;
    rd_chk("set_wins", 32'h58, 32'h2);

    // Reset while ch0 is active
    wr(32'h14, 32'h1);
    idle(3);
    chk("rst_grant", 64'(gch_q.size()), 64'd1);
    if (gch_q.size() > 0) begin
      chk("rst_grant_ch", 64'(gch_q.pop_front()), 64'd0);
      void'(gsrc_q.pop_front()); void'(gdst_q.pop_front()); void'(glen_q.pop_front());
    end
    rst_n = 1'b0;
    idle(2);
    chk("mid_rst_eng_start", 64'(eng_start), 64'd0);
    chk("mid_rst_eng_src", 64'(eng_src), 64'd0);
    chk("mid_rst_irq", 64'(irq), 64'd0);
    rst_n = 1'b1;
    idle(1);
    for (int c = 0; c < 4; c++) rd_chk("post_rst_status", 32'(c * 32 + 24), 32'h0);
    done_pulse(1'b1);
    idle(2);
    rd_chk("late_done_status", 32'h18, 32'h0);
    rd_chk("late_done_irqstat", 32'h200, 32'h0);
    chk("late_done_no_cmd", 64'(gch_q.size()), 64'd0);
    chk("late_done_irq", 64'(irq), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_csr_mc.md
DMA_CSR_MC -- requirements
Module: dma_csr_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels (legal 1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 48, width of src/dst addresses driven to the engine.
REQ-003 SHALL have parameter LEN_WIDTH, default 32, width of the transfer length (bytes).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports cfg_req_valid (input, 1), cfg_req_write (input, 1), cfg_req_addr (input, 32) and cfg_req_wdata (input, 32), forming a single-beat MMIO request that is always accepted.
REQ-007 SHALL have ports cfg_resp_valid (output, 1) and cfg_resp_rdata (output, 32), carrying the registered read response.
REQ-008 SHALL have ports eng_start (output, 1), eng_src (output, ADDR_WIDTH), eng_dst (output, ADDR_WIDTH), eng_len (output, LEN_WIDTH) and eng_ch (output, 3), forming the command issued to the shared DMA engine.
REQ-009 SHALL have ports eng_done (input, 1) and eng_err (input, 1): a one-cycle completion pulse, with eng_err qualified by eng_done (non-resident page or fault).
REQ-010 SHALL have port irq, output, 1, level interrupt = OR over channels of (done|err) & irq_en.

Function
REQ-011 SHALL map channel c registers at byte offset 0x20*c: 0x00 SRC_LO, 0x04 SRC_HI, 0x08 DST_LO, 0x0C DST_HI, 0x10 LEN, 0x14 CTRL, 0x18 STATUS.
REQ-012 SHALL map CTRL as: bit0 START (write-only pulse, reads 0), bit1 IRQ_EN (R/W).
REQ-013 SHALL map STATUS as: bit0 BUSY, bit1 DONE, bit2 ERR; writing 1 to DONE/ERR clears that bit, and BUSY is read-only.
REQ-014 SHALL map global register 0x200 IRQ_STAT, bits[NUM_CH-1:0] = per-channel (DONE|ERR), read-only.
REQ-015 SHALL ignore SRC/DST bits at or above ADDR_WIDTH on write and return them as 0 on read.
REQ-016 SHALL treat unmapped addresses and channels >= NUM_CH as follows: writes ignored, reads return 0.
REQ-017 SHALL return read data one cycle after the request: cfg_resp_valid=1 in cycle N+1 for a read in cycle N, and cfg_resp_valid=0 for writes.
REQ-018 SHALL give each channel an FSM with states IDLE, PEND, ACTIVE.
REQ-019 SHALL move a channel IDLE->PEND on START=1 with LEN!=0; BUSY=1 from the next cycle.
REQ-020 SHALL, on START with LEN==0, leave the channel in IDLE and set DONE=1 the next cycle with no engine command.
REQ-021 SHALL ignore START while the channel is PEND or ACTIVE.
REQ-022 SHALL drop writes to SRC/DST/LEN of a non-IDLE channel.
REQ-023 SHALL allow at most one channel in ACTIVE, the engine being free when no channel is ACTIVE.
REQ-024 SHALL, when the engine is free and any channel is PEND, grant one channel round-robin: priority starts at ch0 after reset and after granting ch k, ch k+1 (mod NUM_CH) has highest priority.
REQ-025 SHALL on grant drive eng_start=1 for exactly one cycle, with eng_src/dst/len/ch holding the granted channel's values, and move that channel to ACTIVE.
REQ-026 SHALL keep eng_src/dst/len/ch stable until eng_done.
REQ-027 SHALL, on eng_done, move the ACTIVE channel to IDLE and set DONE (and ERR if eng_err) the next cycle, clearing BUSY.
REQ-028 SHALL make the earliest next grant the cycle after eng_done.
REQ-029 SHALL ignore eng_done when no channel is ACTIVE.
REQ-030 SHALL give set priority over clear when a W1C of DONE/ERR coincides with its set.
REQ-031 SHALL apply a write in cycle N as visible to a read issued in cycle N+1.

Reset
REQ-032 SHALL, while rst_n=0, force all registers to 0, all FSMs to IDLE, the RR pointer to ch0, and eng_start, cfg_resp_valid and irq to 0.
REQ-033 SHALL, on reset mid-transfer, abandon the transfer (no DONE is set) and ignore any eng_done after reset until a new grant.

Verification
REQ-034 SHALL verify: ch0 SRC=0x1000, DST=0x2000, LEN=64, START -> eng_start pulse with those values, then STATUS=0x1 until eng_done, then 0x2.
REQ-035 SHALL verify: ch0..ch3 all STARTed in the same cycle window -> grant order 0,1,2,3, each grant after the prior eng_done.
REQ-036 SHALL verify: ch1 LEN=0, START -> STATUS=0x2 next cycle, eng_start never asserted.
REQ-037 SHALL verify: IRQ_EN=1 and eng_done with eng_err=1 -> STATUS=0x6, irq=1; W1C 0x6 -> STATUS=0, irq=0.
REQ-038 SHALL verify: while ch2 is ACTIVE, write LEN=0x99 and START -> LEN readback unchanged, no second grant.
REQ-039 SHALL verify: rst_n low during ACTIVE -> all STATUS=0, eng_start=0, and a late eng_done sets nothing.
